// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {remainder, quotient} 33 cycles after accept; divide-by-zero takes 2 cycles.
module div_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        signed_div,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        annul,
   output logic        busy,
   output logic        ready,
   output logic [63:0] result
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIVZERO = 2'd1,
      S_ON      = 2'd2,
      S_END     = 2'd3
   } state_t;

   state_t      state_r;
   logic [4:0]  cnt_r;
   logic [64:0] w_r;
   logic [31:0] divisor_r;
   logic [31:0] a_r;
   logic        signed_r;
   logic        sign_a_r;
   logic        sign_b_r;
   logic        busy_r;
   logic        ready_r;
   logic [63:0] result_r;

   logic [31:0] abs_a_s;
   logic [31:0] abs_b_s;
   logic [64:0] w_shift_s;
   logic [64:0] w_next_s;
   logic [31:0] quo_fix_s;
   logic [31:0] rem_fix_s;

   function automatic logic [31:0] negate_if(input logic neg, input logic [31:0] v);
      if (neg) begin
         return (~v) + 32'd1;
      end else begin
         return v;
      end
   endfunction

   // Operand magnitudes for the accept edge; unsigned operands pass through untouched
   always_comb begin
      abs_a_s = negate_if(signed_div & a[31], a);
      abs_b_s = negate_if(signed_div & b[31], b);
   end

   // One restoring iteration plus the sign fix-up of its outcome
   always_comb begin
      w_shift_s = {w_r[63:0], 1'b0};
      w_next_s  = w_shift_s;
      if (w_shift_s[64:32] >= {1'b0, divisor_r}) begin
         w_next_s[64:32] = w_shift_s[64:32] - {1'b0, divisor_r};
         w_next_s[0]     = 1'b1;
      end else begin
         w_next_s = w_shift_s;
      end
      quo_fix_s = negate_if(signed_r & (sign_a_r ^ sign_b_r), w_next_s[31:0]);
      rem_fix_s = negate_if(signed_r & sign_a_r, w_next_s[63:32]);
   end

   // Control FSM with registered busy/ready/result
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r   <= S_IDLE;
         cnt_r     <= 5'd0;
         w_r       <= 65'd0;
         divisor_r <= 32'd0;
         a_r       <= 32'd0;
         signed_r  <= 1'b0;
         sign_a_r  <= 1'b0;
         sign_b_r  <= 1'b0;
         busy_r    <= 1'b0;
         ready_r   <= 1'b0;
         result_r  <= 64'd0;
      end else begin
         ready_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start && !annul) begin
                  signed_r  <= signed_div;
                  sign_a_r  <= a[31];
                  sign_b_r  <= b[31];
                  a_r       <= a;
                  divisor_r <= abs_b_s;
                  w_r       <= {33'd0, abs_a_s};
                  cnt_r     <= 5'd0;
                  busy_r    <= 1'b1;
                  state_r   <= (b == 32'd0) ? S_DIVZERO : S_ON;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            S_DIVZERO: begin
               if (annul) begin
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  result_r <= {a_r, 32'hFFFF_FFFF};
                  ready_r  <= 1'b1;
                  state_r  <= S_END;
               end
            end
            S_ON: begin
               if (annul) begin
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  w_r   <= w_next_s;
                  cnt_r <= cnt_r + 5'd1;
                  if (cnt_r == 5'd31) begin
                     result_r <= {rem_fix_s, quo_fix_s};
                     ready_r  <= 1'b1;
                     state_r  <= S_END;
                  end else begin
                     state_r <= S_ON;
                  end
               end
            end
            S_END: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_r;
   assign ready  = ready_r;
   assign result = result_r;

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider serving the MIPS DIV/DIVU instructions, which the single-cycle ALU does not execute. The EX stage hands it operands and a start request, stalls the pipeline while it is busy, and takes its 64-bit {HI, LO} result into the HI/LO path when it signals ready. Radix-2 restoring division: one quotient bit per cycle, sign fix-up for signed operation, dedicated divide-by-zero path, and cancel support for exception flush.

## Interface
- No parameters; data width fixed at 32, result width 64.
- clk  in  1  system clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request a division; sampled only in IDLE
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- a  in  32  dividend (rs); sampled with start
- b  in  32  divisor (rt); sampled with start
- annul  in  1  cancel the division in flight (exception/flush)
- busy  out  1  1 in every state except IDLE; EX stage stalls on busy | start
- ready  out  1  one-cycle pulse: result valid
- result  out  64  {remainder (HI), quotient (LO)}; registered

## Operation
- States: IDLE, DIVZERO, ON, END.
- IDLE: if start & ~annul -> latch signed_div, a, b, and sign bits of a and b; b==0 -> DIVZERO, else -> ON with cnt=0. Otherwise stay.
- Operand prep on accept: signed_div & a[31] -> dividend = -a, else a; same for divisor with b. Unsigned: used unmodified.
- ON: working register W[64:0] = {33'b0, |dividend|} at entry. Each cycle: shift W left 1; if W[64:32] >= {1'b0,|divisor|} then W[64:32] -= divisor, W[0]=1. cnt increments; after cnt reaches 31 (32 iterations) -> END.
- Sign fix-up (signed only, applied when entering END): quotient negated if sign(a)!=sign(b); remainder negated if a negative. Remainder always has dividend's sign.
- 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0 (natural wrap of the negate; no trap).
- DIVZERO: one cycle, -> END with result = {a_latched, 32'hFFFFFFFF} (both signed and unsigned).
- END: result register loaded, ready=1 for this cycle only; -> IDLE unconditionally. start during END ignored.
- annul high in DIVZERO, ON or END: -> IDLE at next edge, ready stays 0, result keeps previous value. annul in IDLE blocks acceptance of start.
- result holds its value from END until the next END (not cleared on return to IDLE).

## Timing
- Reset (resetn low, asynchronous): state=IDLE, cnt=0, W=0, busy=0, ready=0, result=64'h0. Reset mid-division discards it fully; first accept after release starts clean.
- Accept edge = cycle 0. Normal divide: ON during cycles 1-32, END (ready=1, result valid) in cycle 33, IDLE in cycle 34. Latency 33 cycles start-to-ready.
- Divide by zero: DIVZERO in cycle 1, END/ready in cycle 2.
- busy is registered-state decoded: 0 in cycle 0 (IDLE), 1 from cycle 1 through the END cycle inclusive.
- Back-to-back: a new start is accepted in the first IDLE cycle after END; the pipeline must present the next instruction's start there, not a held copy of the old one.
- ready and annul in same END cycle: annul has no effect on that cycle's ready (already asserted); result is still loaded. Consumer is responsible for discarding.
- No combinational path from inputs to any output.

## Test plan
- DIVU a=100, b=7 -> ready exactly in cycle 33, result={32'd2, 32'd14}; busy high cycles 1-33, low cycle 34.
- DIV a=-7 (0xFFFFFFF9), b=2 -> result={0xFFFFFFFF, 0xFFFFFFFD}; DIV a=7, b=-2 -> {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}; DIVU 0xFFFFFFFF / 1 -> {0, 0xFFFFFFFF}; DIVU 5 / 9 -> {5, 0}.
- DIVU a=0x1234, b=0 -> ready in cycle 2, result={0x00001234, 0xFFFFFFFF}.
- Start DIVU 100/7, assert annul in cycle 10 -> IDLE at cycle 11, no ready, result unchanged; start DIVU 9/3 in cycle 12 -> ready cycle 45, result={0,3}.
- Drop resetn in cycle 15 of a division -> busy/ready/result immediately 0, state IDLE; after release, DIV -9/4 -> {0xFFFFFFFF, 0xFFFFFFFE} after 33 cycles.
